// File: rtl/count_ones_sched_if.sv
// rtl/count_ones_sched_if.sv - request/result bundle between clients and the shared ones counter
interface count_ones_sched_if #(
  parameter int data_width  = 4,
  parameter int count_width = 3,
  parameter int num_req     = 4,
  parameter int id_width    = 2
);
  logic [num_req-1:0]            req;
  logic [num_req*data_width-1:0] data_bus;
  logic [num_req-1:0]            ack;
  logic                          busy;
  logic [count_width-1:0]        bit_count;
  logic                          done;
  logic [id_width-1:0]           done_id;

  // Client side: raises requests and presents words, observes grants and results.
  modport master (
    output req, data_bus,
    input  ack, busy, bit_count, done, done_id
  );

  // Scheduler side.
  modport slave (
    input  req, data_bus,
    output ack, busy, bit_count, done, done_id
  );
endinterface

// File: rtl/count_ones_sched.sv
// rtl/count_ones_sched.sv - round-robin scheduler around one serial shift-and-add ones counter
module count_ones_sched #(
  parameter int data_width  = 4,
  parameter int count_width = 3,
  parameter int num_req     = 4,
  parameter int id_width    = 2
) (
  input  logic               clk,
  input  logic               reset,
  count_ones_sched_if.slave  bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [data_width-1:0]   temp_q, temp_d;
  logic [count_width-1:0]  count_q, count_d;
  logic [id_width-1:0]     grant_q, grant_d;
  logic [id_width-1:0]     ptr_q, ptr_d;
  logic [num_req-1:0]      ack_q, ack_d;
  logic                    done_q, done_d;
  logic [count_width-1:0]  bit_count_q, bit_count_d;
  logic [id_width-1:0]     done_id_q, done_id_d;

  logic                    found;
  logic [id_width-1:0]     winner;
  logic [id_width-1:0]     idx;

  // Rotating priority scan: first pending request at or after ptr wins; id_width arithmetic wraps mod num_req.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = ptr_q;
    for (int i = 0; i < num_req; i++) begin
      idx = ptr_q + id_width'(i);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Next-state logic: grant and capture in IDLE, one bit per clock in SHIFT, exit as soon as the word is empty.
  always_comb begin
    state_d     = state_q;
    temp_d      = temp_q;
    count_d     = count_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    ack_d       = '0;
    done_d      = 1'b0;
    bit_count_d = bit_count_q;
    done_id_d   = done_id_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          temp_d  = bus.data_bus[winner*data_width +: data_width];
          count_d = '0;
          grant_d = winner;
          ack_d   = num_req'(1) << winner;
          ptr_d   = winner + id_width'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (temp_q != '0) begin
          count_d = count_q + count_width'(temp_q[0]);
          temp_d  = temp_q >> 1;
        end else begin
          bit_count_d = count_q;
          done_id_d   = grant_q;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight job without a done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      temp_q      <= '0;
      count_q     <= '0;
      grant_q     <= '0;
      ptr_q       <= '0;
      ack_q       <= '0;
      done_q      <= 1'b0;
      bit_count_q <= '0;
      done_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      temp_q      <= temp_d;
      count_q     <= count_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      bit_count_q <= bit_count_d;
      done_id_q   <= done_id_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = done_q;
  assign bus.bit_count = bit_count_q;
  assign bus.done_id   = done_id_q;

endmodule

// File: tb/tb_count_ones_sched.sv
// tb/tb_count_ones_sched.sv - directed table-driven bench for count_ones_sched
module tb_count_ones_sched;
  localparam int DW = 4;
  localparam int CW = 3;
  localparam int NR = 4;
  localparam int IW = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  count_ones_sched_if #(.data_width(DW), .count_width(CW), .num_req(NR), .id_width(IW)) bus ();

  count_ones_sched #(.data_width(DW), .count_width(CW), .num_req(NR), .id_width(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [3:0] data;
    int         exp_count;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int id);
    int seen;
    id   = -1;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      tick();
      if (bus.ack != '0) begin
        seen = 1;
        for (int k = 0; k < NR; k++) if (bus.ack[k]) id = k;
        chk("ack_onehot", $countones(bus.ack), 1);
      end
    end
    if (seen == 0) chk("ack_timeout", 0, 1);
  endtask

  // Called right after the grant edge; lat counts edges after it until done is seen.
  task automatic wait_done(output int lat, output int busy_n);
    int seen;
    lat    = 0;
    busy_n = 0;
    seen   = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      tick();
      lat++;
      if (lat == 1) chk("ack_one_cycle", int'(bus.ack), 0);
      if (bus.done) seen = 1;
      else if (bus.busy) busy_n++;
    end
    if (seen == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gid, lat, bn, ng, nd;
    int g[8];
    int d_id[8];
    int d_cnt[8];
    int exp_g[4];
    int exp_c[4];

    vecs[0] = '{0, 4'b1011, 3, 5};
    vecs[1] = '{1, 4'b0000, 0, 1};
    vecs[2] = '{2, 4'b1111, 4, 5};
    vecs[3] = '{3, 4'b0100, 1, 4};
    vecs[4] = '{0, 4'b0001, 1, 2};
    vecs[5] = '{1, 4'b0110, 2, 4};

    bus.req      = '0;
    bus.data_bus = '0;
    reset        = 1'b1;
    #12;
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_bit_count", int'(bus.bit_count), 0);
    chk("rst_done_id", int'(bus.done_id), 0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      bus.data_bus[vecs[v].id*DW +: DW] = vecs[v].data;
      bus.req = NR'(1) << vecs[v].id;
      wait_ack(gid);
      chk("vec_grant_id", gid, vecs[v].id);
      chk("vec_busy_at_grant", int'(bus.busy), 1);
      bus.req = '0;
      wait_done(lat, bn);
      chk("vec_latency", lat, vecs[v].exp_lat);
      chk("vec_busy_cycles", bn + 1, vecs[v].exp_lat);
      chk("vec_busy_in_done", int'(bus.busy), 0);
      chk("vec_bit_count", int'(bus.bit_count), vecs[v].exp_count);
      chk("vec_done_id", int'(bus.done_id), vecs[v].id);
      tick();
      chk("vec_done_one_cycle", int'(bus.done), 0);
    end

    // All four request at once and drop on their own ack: rotation 0,1,2,3.
    pulse_reset();
    bus.data_bus = {4'b0000, 4'b0111, 4'b1000, 4'b0011};
    exp_g = '{0, 1, 2, 3};
    exp_c = '{2, 1, 3, 0};
    bus.req = 4'b1111;
    ng = 0;
    nd = 0;
    for (int i = 0; i < 100 && nd < 4; i++) begin
      tick();
      if (bus.ack != '0 && ng < 8) begin
        for (int k = 0; k < NR; k++) if (bus.ack[k]) g[ng] = k;
        ng++;
        bus.req = bus.req & ~bus.ack;
      end
      if (bus.done && nd < 8) begin
        d_id[nd]  = int'(bus.done_id);
        d_cnt[nd] = int'(bus.bit_count);
        nd++;
      end
    end
    chk("rr_grants", ng, 4);
    chk("rr_dones", nd, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ng) chk("rr_grant_order", g[i], exp_g[i]);
      if (i < nd) chk("rr_done_id", d_id[i], exp_g[i]);
      if (i < nd) chk("rr_done_count", d_cnt[i], exp_c[i]);
    end

    // Requesters 0 and 2 hold req continuously: grants must alternate.
    pulse_reset();
    bus.data_bus = {4'b0000, 4'b0010, 4'b0000, 4'b0001};
    bus.req = 4'b0101;
    ng = 0;
    nd = 0;
    for (int i = 0; i < 100 && nd < 4; i++) begin
      tick();
      if (bus.ack != '0 && ng < 8) begin
        for (int k = 0; k < NR; k++) if (bus.ack[k]) g[ng] = k;
        ng++;
        if (ng == 4) bus.req = '0;
      end
      if (bus.done && nd < 8) begin
        d_id[nd]  = int'(bus.done_id);
        d_cnt[nd] = int'(bus.bit_count);
        nd++;
      end
    end
    chk("alt_grants", ng, 4);
    chk("alt_dones", nd, 4);
    for (int i = 0; i < 4 && i < ng; i++) chk("alt_grant_order", g[i], (i % 2 == 0) ? 0 : 2);
    for (int i = 0; i < 4 && i < nd; i++) chk("alt_done_count", d_cnt[i], 1);

    // Reset in the middle of a count: outputs clear at once, job is dropped, requester is regranted.
    bus.data_bus = {4'b0000, 4'b0000, 4'b0000, 4'b1000};
    bus.req = 4'b0001;
    wait_ack(gid);
    chk("mid_grant_id", gid, 0);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_ack", int'(bus.ack), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_bit_count", int'(bus.bit_count), 0);
    chk("mid_rst_done_id", int'(bus.done_id), 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_rst_no_done", int'(bus.done), 0);
    reset = 1'b0;
    wait_ack(gid);
    chk("mid_regrant_id", gid, 0);
    bus.req = '0;
    wait_done(lat, bn);
    chk("mid_latency", lat, 5);
    chk("mid_bit_count", int'(bus.bit_count), 1);
    chk("mid_done_id", int'(bus.done_id), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
